// File: rtl/em_buf_alloc_arb_if.sv
// Request/grant/free bundle between the edit-memory write engines and the EM buffer allocator.
interface em_buf_alloc_arb_if #(
  parameter int BPTR_NBITS = 4,
  parameter int NREQ       = 3
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       buf_valid;
  logic [BPTR_NBITS-1:0] buf_ptr;
  logic                  buf_available;
  logic                  free_valid;
  logic [BPTR_NBITS-1:0] free_ptr;

  modport master (output req, free_valid, free_ptr, input buf_valid, buf_ptr, buf_available);
  modport slave  (input req, free_valid, free_ptr, output buf_valid, buf_ptr, buf_available);
endinterface

// File: rtl/em_buf_alloc_arb.sv
// EM buffer allocator: free-pointer pool (circular FIFO) plus round-robin prefetch arbiter.
// Optional EM_BUF_ALLOC_STATS_EN adds saturating grant/no-buffer counters.
module em_buf_alloc_arb #(
  parameter int BPTR_NBITS = 4,
  parameter int NREQ       = 3,
  parameter int NUM_BUFS   = 1 << BPTR_NBITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  em_buf_alloc_arb_if.slave     bus,
  output logic                  init_done,
  output logic [BPTR_NBITS:0]   free_count,
  output logic                  err_overflow
`ifdef EM_BUF_ALLOC_STATS_EN
  ,
  output logic [31:0]           stat_alloc_cnt,
  output logic [31:0]           stat_nobuf_cnt
`endif
);
  localparam int IW = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
  localparam int RW = $clog2(NREQ);
  localparam int CW = BPTR_NBITS + 1;
  localparam logic [CW-1:0] FULL = CW'(NUM_BUFS);
  localparam logic [IW-1:0] LAST = IW'(NUM_BUFS - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state, state_nx;
  logic [BPTR_NBITS-1:0] mem [NUM_BUFS];
  logic [IW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic [RW-1:0]         rr_last, winner, idx;
  logic                  grant, do_alloc, do_wr, drop_free;
  logic [BPTR_NBITS-1:0] wr_data;
  int                    j;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    winner = rr_last;
    grant  = 1'b0;
    j      = 0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(rr_last) + i;
      if (j >= NREQ) j = j - NREQ;
      idx = RW'(j);
      if (!grant && bus.req[idx]) begin
        grant  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    do_wr     = 1'b0;
    wr_data   = '0;
    drop_free = 1'b0;
    do_alloc  = 1'b0;
    case (state)
      S_INIT: begin
        // count doubles as the init pointer: entry k holds pointer k
        do_wr     = 1'b1;
        wr_data   = count[BPTR_NBITS-1:0];
        drop_free = bus.free_valid;
        if (count == FULL - CW'(1)) state_nx = S_RUN;
      end
      S_RUN: begin
        do_alloc  = grant && (count != '0);
        do_wr     = bus.free_valid && (count != FULL);
        wr_data   = bus.free_ptr;
        drop_free = bus.free_valid && (count == FULL);
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[tail] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_INIT;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      rr_last           <= RW'(NREQ - 1);
      init_done         <= 1'b0;
      err_overflow      <= 1'b0;
      bus.buf_valid     <= '0;
      bus.buf_ptr       <= '0;
      bus.buf_available <= 1'b0;
    end else begin
      state             <= state_nx;
      init_done         <= (state_nx == S_RUN);
      if (do_wr)    tail <= (tail == LAST) ? '0 : tail + IW'(1);
      if (do_alloc) head <= (head == LAST) ? '0 : head + IW'(1);
      count             <= count + CW'(do_wr) - CW'(do_alloc);
      if (drop_free) err_overflow <= 1'b1;
      bus.buf_valid     <= '0;
      bus.buf_available <= do_alloc;
      bus.buf_ptr       <= do_alloc ? mem[head] : '0;
      if (state == S_RUN && grant) begin
        rr_last       <= winner;
        bus.buf_valid <= NREQ'(1) << winner;
      end
    end
  end

  assign free_count = count;

`ifdef EM_BUF_ALLOC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_alloc_cnt <= '0;
      stat_nobuf_cnt <= '0;
    end else if (state == S_RUN && grant) begin
      if (count != '0) begin
        if (stat_alloc_cnt != 32'hFFFF_FFFF) stat_alloc_cnt <= stat_alloc_cnt + 32'd1;
      end else begin
        if (stat_nobuf_cnt != 32'hFFFF_FFFF) stat_nobuf_cnt <= stat_nobuf_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_em_buf_alloc_arb.sv
// Bench for em_buf_alloc_arb: directed scenarios plus random traffic against a queue-based pool model.
module tb_em_buf_alloc_arb;
  localparam int BW = 4, NREQ = 3, NB = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  em_buf_alloc_arb_if #(.BPTR_NBITS(BW), .NREQ(NREQ)) bus ();
  logic          init_done;
  logic [BW:0]   free_count;
  logic          err_overflow;
`ifdef EM_BUF_ALLOC_STATS_EN
  logic [31:0]   stat_alloc_cnt, stat_nobuf_cnt;
`endif

  em_buf_alloc_arb #(.BPTR_NBITS(BW), .NREQ(NREQ), .NUM_BUFS(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .init_done    (init_done),
    .free_count   (free_count),
    .err_overflow (err_overflow)
`ifdef EM_BUF_ALLOC_STATS_EN
    ,
    .stat_alloc_cnt (stat_alloc_cnt),
    .stat_nobuf_cnt (stat_nobuf_cnt)
`endif
  );

  int errors = 0, checks = 0;

  // Reference model: free pool as a queue, plain round-robin pointer.
  int pool[$];
  int m_rr, m_icnt, s_alloc, s_nobuf;
  bit m_run, m_err;
  int e_valid, e_ptr, e_avail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    pool.delete();
    m_rr = NREQ - 1; m_icnt = 0; m_run = 0; m_err = 0;
    s_alloc = 0; s_nobuf = 0;
    e_valid = 0; e_ptr = 0; e_avail = 0;
  endtask

  task automatic model_step(input int r, input bit fv, input int fp);
    int sz0, w;
    bit found;
    e_valid = 0; e_ptr = 0; e_avail = 0;
    if (!m_run) begin
      if (fv) m_err = 1;
      m_icnt++;
      if (m_icnt == NB) begin
        m_run = 1;
        for (int k = 0; k < NB; k++) pool.push_back(k);
      end
    end else begin
      sz0 = pool.size();
      if (r != 0) begin
        found = 0; w = m_rr;
        for (int i = 1; i <= NREQ; i++) begin
          if (!found && ((r >> ((m_rr + i) % NREQ)) & 1) != 0) begin
            found = 1; w = (m_rr + i) % NREQ;
          end
        end
        m_rr = w;
        e_valid = 1 << w;
        if (sz0 > 0) begin
          e_ptr = pool.pop_front(); e_avail = 1; s_alloc++;
        end else s_nobuf++;
      end
      if (fv) begin
        if (sz0 == NB) m_err = 1;
        else pool.push_back(fp);
      end
    end
  endtask

  // Called at a negedge; drives, advances the model, checks after the edge, returns at next negedge.
  task automatic step(input int r, input bit fv, input int fp);
    bus.req        = NREQ'(r);
    bus.free_valid = fv;
    bus.free_ptr   = BW'(fp);
    model_step(r, fv, fp);
    @(posedge clk); #1;
    chk("buf_valid", 32'(bus.buf_valid), e_valid);
    chk("buf_ptr", 32'(bus.buf_ptr), e_ptr);
    chk("buf_available", 32'(bus.buf_available), e_avail);
    chk("free_count", 32'(free_count), m_run ? pool.size() : m_icnt);
    chk("init_done", 32'(init_done), 32'(m_run));
    chk("err_overflow", 32'(err_overflow), 32'(m_err));
`ifdef EM_BUF_ALLOC_STATS_EN
    chk("stat_alloc_cnt", stat_alloc_cnt, s_alloc);
    chk("stat_nobuf_cnt", stat_nobuf_cnt, s_nobuf);
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.free_valid = 1'b0; bus.free_ptr = '0;
    #1;
    m_reset();
    chk("rst_buf_valid", 32'(bus.buf_valid), 0);
    chk("rst_buf_ptr", 32'(bus.buf_ptr), 0);
    chk("rst_buf_available", 32'(bus.buf_available), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_free_count", 32'(free_count), 0);
    chk("rst_err_overflow", 32'(err_overflow), 0);
`ifdef EM_BUF_ALLOC_STATS_EN
    chk("rst_stat_alloc", stat_alloc_cnt, 0);
    chk("rst_stat_nobuf", stat_nobuf_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_phase(input int n, input int free_pct, input int req_pct);
    int r;
    bit fv;
    for (int c = 0; c < n; c++) begin
      r  = ($urandom_range(0, 99) < req_pct) ? int'($urandom_range(1, 7)) : 0;
      fv = ($urandom_range(0, 99) < free_pct);
      step(r, fv, int'($urandom_range(0, NB - 1)));
    end
  endtask

  initial begin
    do_reset();
    // pool initialisation, no traffic
    repeat (16) step(0, 0, 0);
    chk("init_fc16", 32'(free_count), 16);
    // single requester: pointers 0..3
    repeat (4) step(3'b001, 0, 0);
    chk("after4_fc", 32'(free_count), 12);
    // rotation across all, then across the sparse pattern
    repeat (6) step(3'b111, 0, 0);
    repeat (4) step(3'b101, 0, 0);
    // drain the last two pointers and keep requesting on an empty pool
    repeat (4) step(3'b010, 0, 0);
    chk("empty_ptr", 32'(bus.buf_ptr), 0);
    step(0, 1, 7);
    step(3'b010, 0, 0);
    chk("refill_ptr7", 32'(bus.buf_ptr), 7);
    // random traffic: refill-heavy then drain-heavy
    rand_phase(150, 70, 30);
    rand_phase(150, 20, 80);
    // clean pool, free while full
    do_reset();
    repeat (16) step(0, 0, 0);
    step(0, 1, 3);
    chk("ovf_full", 32'(err_overflow), 1);
    repeat (3) step(0, 0, 0);
    repeat (5) step(3'b001, 0, 0);
    // reset with 5 pointers outstanding, free during INIT
    do_reset();
    repeat (5) step(0, 0, 0);
    step(0, 1, 9);
    repeat (10) step(0, 0, 0);
    repeat (3) step(3'b100, 0, 0);
    rand_phase(200, 40, 60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
